// File: rtl/pc_pkg.sv
// Shared defaults and operation encoding for the program counter with
// return-address stack.
package pc_pkg;

  localparam int PSIZE_DEFAULT     = 6;
  localparam int RAS_DEPTH_DEFAULT = 4;

  typedef enum logic [2:0] {
    OP_HOLD   = 3'd0,
    OP_INCR   = 3'd1,
    OP_BRANCH = 3'd2,
    OP_JUMP   = 3'd3,
    OP_CALL   = 3'd4,
    OP_RET    = 3'd5
  } pc_op_t;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: LIFO storage with a reset-cleared depth counter.
// Storage itself is never reset; entries at or above depth are unreachable.
module pc_ras
  import pc_pkg::*;
#(
  parameter int Psize    = PSIZE_DEFAULT,
  parameter int RasDepth = RAS_DEPTH_DEFAULT
) (
  input  logic                             clk,
  input  logic                             nReset,
  input  logic                             push,
  input  logic                             pop,
  input  logic [Psize-1:0]                 wdata,
  output logic [Psize-1:0]                 rdata,
  output logic [$clog2(RasDepth+1)-1:0]    depth
);

  localparam int DW = $clog2(RasDepth + 1);
  localparam int AW = $clog2(RasDepth);
  localparam logic [DW-1:0] FULL_DEPTH = DW'(RasDepth);

  logic [Psize-1:0] mem_r [2**AW];
  logic [DW-1:0]    depth_r;
  logic [DW-1:0]    top_s;
  logic [AW-1:0]    wr_idx_s;
  logic [AW-1:0]    rd_idx_s;

  // depth-1 always fits in AW bits whenever a read is meaningful (depth >= 1)
  assign top_s    = depth_r - DW'(1);
  assign wr_idx_s = depth_r[AW-1:0];
  assign rd_idx_s = top_s[AW-1:0];
  assign rdata    = mem_r[rd_idx_s];
  assign depth    = depth_r;

  // Stack storage write; pushes are only issued when not full
  always_ff @(posedge clk) begin
    if (push && (depth_r != FULL_DEPTH)) begin
      mem_r[wr_idx_s] <= wdata;
    end
  end

  // Depth counter with guarded increment/decrement
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      depth_r <= '0;
    end else if (pop && (depth_r != DW'(0))) begin
      depth_r <= depth_r - DW'(1);
    end else if (push && (depth_r != FULL_DEPTH)) begin
      depth_r <= depth_r + DW'(1);
    end else begin
      depth_r <= depth_r;
    end
  end

endmodule

// File: rtl/pc_stack.sv
// Program counter with relative branch, absolute jump, and call/return
// through a return-address stack; one operation per enabled cycle.
module pc_stack
  import pc_pkg::*;
#(
  parameter int Psize    = PSIZE_DEFAULT,
  parameter int RasDepth = RAS_DEPTH_DEFAULT
) (
  input  logic                             clk,
  input  logic                             nReset,
  input  logic                             en,
  input  logic                             branch,
  input  logic [Psize-1:0]                 offset,
  input  logic                             jump,
  input  logic                             call,
  input  logic                             ret,
  input  logic [Psize-1:0]                 target,
  output logic [Psize-1:0]                 PCout,
  output logic [$clog2(RasDepth+1)-1:0]    depth,
  output logic                             ras_full,
  output logic                             ras_empty,
  output logic                             ras_err
);

  localparam int DW = $clog2(RasDepth + 1);
  localparam logic [DW-1:0] FULL_DEPTH = DW'(RasDepth);

  pc_op_t           op_s;
  logic [Psize-1:0] pc_r;
  logic [Psize-1:0] pc_next_s;
  logic [Psize-1:0] addend_s;
  logic [Psize-1:0] sum_s;
  logic [Psize-1:0] rdata_s;
  logic             push_s;
  logic             pop_s;
  logic             err_set_s;
  logic             err_r;

  pc_ras #(
    .Psize    (Psize),
    .RasDepth (RasDepth)
  ) u_ras (
    .clk    (clk),
    .nReset (nReset),
    .push   (push_s),
    .pop    (pop_s),
    .wdata  (sum_s),
    .rdata  (rdata_s),
    .depth  (depth)
  );

  // Priority decode: ret > call > jump > branch > increment
  always_comb begin
    op_s = OP_HOLD;
    if (!en) begin
      op_s = OP_HOLD;
    end else if (ret) begin
      op_s = OP_RET;
    end else if (call) begin
      op_s = OP_CALL;
    end else if (jump) begin
      op_s = OP_JUMP;
    end else if (branch) begin
      op_s = OP_BRANCH;
    end else begin
      op_s = OP_INCR;
    end
  end

  // Single shared adder; its +1 result doubles as the call return address.
  // Offset is already Psize wide, so modulo addition equals sign-extended addition.
  assign addend_s  = (op_s == OP_BRANCH) ? offset : Psize'(1);
  assign sum_s     = pc_r + addend_s;
  assign ras_full  = (depth == FULL_DEPTH);
  assign ras_empty = (depth == DW'(0));

  // Next-PC selection and stack/error control
  always_comb begin
    pc_next_s = pc_r;
    push_s    = 1'b0;
    pop_s     = 1'b0;
    err_set_s = 1'b0;
    case (op_s)
      OP_HOLD: pc_next_s = pc_r;
      OP_INCR, OP_BRANCH: pc_next_s = sum_s;
      OP_JUMP: pc_next_s = target;
      OP_CALL: begin
        pc_next_s = target;
        if (ras_full) begin
          err_set_s = 1'b1;
        end else begin
          push_s = 1'b1;
        end
      end
      OP_RET: begin
        if (ras_empty) begin
          pc_next_s = sum_s;
          err_set_s = 1'b1;
        end else begin
          pc_next_s = rdata_s;
          pop_s     = 1'b1;
        end
      end
      default: pc_next_s = pc_r;
    endcase
  end

  // PC register and sticky error flag
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      pc_r  <= '0;
      err_r <= 1'b0;
    end else begin
      pc_r  <= pc_next_s;
      err_r <= err_r | err_set_s;
    end
  end

  assign PCout   = pc_r;
  assign ras_err = err_r;

endmodule

// File: tb/tb_pc_stack.sv
// Scoreboard bench for pc_stack: directed scenarios plus random traffic,
// checked against a queue-based reference model.
module tb_pc_stack;

  logic       clk;
  logic       nReset;
  logic       en;
  logic       branch;
  logic [5:0] offset;
  logic       jump;
  logic       call;
  logic       ret;
  logic [5:0] target;
  logic [5:0] PCout;
  logic [2:0] depth;
  logic       ras_full;
  logic       ras_empty;
  logic       ras_err;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [5:0] pc;
    logic [2:0] depth;
    logic       full;
    logic       empty;
    logic       err;
  } exp_t;

  exp_t exp_q[$];

  // reference model state
  int m_pc;
  int m_stack[$];
  bit m_err;

  pc_stack dut (
    .clk       (clk),
    .nReset    (nReset),
    .en        (en),
    .branch    (branch),
    .offset    (offset),
    .jump      (jump),
    .call      (call),
    .ret       (ret),
    .target    (target),
    .PCout     (PCout),
    .depth     (depth),
    .ras_full  (ras_full),
    .ras_empty (ras_empty),
    .ras_err   (ras_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input exp_t want);
    compared++;
    if (PCout !== want.pc || depth !== want.depth || ras_full !== want.full ||
        ras_empty !== want.empty || ras_err !== want.err) begin
      mismatched++;
      $display("FAIL %s: got pc=%0d depth=%0d full=%0b empty=%0b err=%0b, want pc=%0d depth=%0d full=%0b empty=%0b err=%0b",
               name, PCout, depth, ras_full, ras_empty, ras_err,
               want.pc, want.depth, want.full, want.empty, want.err);
    end
  endtask

  function automatic exp_t model_view();
    exp_t e;
    e.pc    = 6'(m_pc);
    e.depth = 3'(m_stack.size());
    e.full  = (m_stack.size() == 4);
    e.empty = (m_stack.size() == 0);
    e.err   = m_err;
    return e;
  endfunction

  task automatic model_reset();
    m_pc = 0;
    m_stack.delete();
    m_err = 1'b0;
  endtask

  task automatic idle_inputs();
    en = 1'b0; branch = 1'b0; offset = 6'd0; jump = 1'b0;
    call = 1'b0; ret = 1'b0; target = 6'd0;
  endtask

  // Drive one cycle of requests and queue the expected result
  task automatic step(input bit e, input bit b, input logic [5:0] off,
                      input bit j, input bit c, input bit r, input logic [5:0] tgt);
    int so;
    @(negedge clk);
    en = e; branch = b; offset = off; jump = j; call = c; ret = r; target = tgt;
    if (e) begin
      if (r) begin
        if (m_stack.size() > 0) m_pc = m_stack.pop_back();
        else begin
          m_pc  = (m_pc + 1) % 64;
          m_err = 1'b1;
        end
      end else if (c) begin
        if (m_stack.size() < 4) m_stack.push_back((m_pc + 1) % 64);
        else m_err = 1'b1;
        m_pc = int'(tgt);
      end else if (j) begin
        m_pc = int'(tgt);
      end else if (b) begin
        so   = (int'(off) >= 32) ? int'(off) - 64 : int'(off);
        m_pc = (((m_pc + so) % 64) + 64) % 64;
      end else begin
        m_pc = (m_pc + 1) % 64;
      end
    end
    exp_q.push_back(model_view());
  endtask

  task automatic do_reset();
    @(negedge clk);
    nReset = 1'b0;
    idle_inputs();
    model_reset();
    #1;
    check("reset_state", model_view());
    @(negedge clk);
    nReset = 1'b1;
  endtask

  // Monitor: compare DUT state against the oldest queued expectation after each edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("scoreboard", e);
      end
    end
  end

  initial begin
    nReset = 1'b0;
    idle_inputs();
    model_reset();
    #2;
    check("power_on_reset", model_view());
    do_reset();

    // free-running count through the wrap
    for (int i = 0; i < 70; i++) step(1, 0, 6'd0, 0, 0, 0, 6'd0);

    // relative branches, including negative offset and wrap
    step(1, 0, 6'd0, 1, 0, 0, 6'd10);
    step(1, 1, 6'b111101, 0, 0, 0, 6'd0);
    step(1, 1, 6'd5, 0, 0, 0, 6'd0);
    step(1, 1, 6'd0, 0, 0, 0, 6'd0);
    step(1, 0, 6'd0, 1, 0, 0, 6'd62);
    step(1, 1, 6'd4, 0, 0, 0, 6'd0);

    // simple call / return
    step(1, 0, 6'd0, 1, 0, 0, 6'd3);
    step(1, 0, 6'd0, 0, 1, 0, 6'd20);
    step(1, 0, 6'd0, 0, 0, 0, 6'd0);
    step(1, 0, 6'd0, 0, 0, 0, 6'd0);
    step(1, 0, 6'd0, 0, 0, 1, 6'd0);

    // overflow on the fifth nested call, then LIFO unwinding
    for (int i = 0; i < 5; i++) step(1, 0, 6'd0, 0, 1, 0, 6'(40 + i * 3));
    for (int i = 0; i < 4; i++) step(1, 0, 6'd0, 0, 0, 1, 6'd0);

    // underflow and priority
    do_reset();
    step(1, 0, 6'd0, 1, 0, 0, 6'd9);
    step(1, 0, 6'd0, 0, 0, 1, 6'd0);
    step(1, 1, 6'd7, 1, 1, 0, 6'd33);
    step(1, 1, 6'd7, 1, 1, 1, 6'd50);
    step(1, 1, 6'd3, 1, 0, 0, 6'd17);

    // enable low holds everything
    step(0, 0, 6'd0, 0, 1, 0, 6'd5);
    step(0, 1, 6'd9, 1, 0, 1, 6'd5);

    // random traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 7) != 0), ($urandom_range(0, 3) == 0), 6'($urandom),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) == 0), 6'($urandom));
    end

    // asynchronous reset in the middle of a cycle after two calls
    do_reset();
    step(1, 0, 6'd0, 0, 1, 0, 6'd12);
    step(1, 0, 6'd0, 0, 1, 0, 6'd25);
    @(posedge clk);
    #3;
    nReset = 1'b0;
    idle_inputs();
    model_reset();
    #1;
    check("async_reset", model_view());
    @(negedge clk);
    nReset = 1'b1;
    step(1, 0, 6'd0, 0, 0, 0, 6'd0);
    step(1, 0, 6'd0, 0, 1, 0, 6'd30);

    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pc_stack.md
PC_STACK -- requirements
Module: pc_stack

Interface
REQ-001 Parameter Psize, default 6: PC width in bits (2^Psize instruction words).
REQ-002 Parameter RasDepth, default 4: return-address stack entries, minimum 2.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 nReset  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  advance enable; 0 holds PCout and the stack unchanged.
REQ-006 branch  input  1  relative branch request.
REQ-007 offset  input  Psize  two's-complement branch offset.
REQ-008 jump  input  1  absolute jump request.
REQ-009 call  input  1  subroutine call request: push return address, then jump.
REQ-010 ret  input  1  subroutine return request: pop stack into PC.
REQ-011 target  input  Psize  absolute address for jump and call.
REQ-012 PCout  output  Psize  current instruction address, registered.
REQ-013 depth  output  clog2(RasDepth+1)  number of valid stack entries.
REQ-014 ras_full / ras_empty  output  1 each  depth==RasDepth / depth==0, combinational from depth.
REQ-015 ras_err  output  1  sticky flag: overflow or underflow has occurred.

Function
REQ-016 When en=0, PCout, stack contents, depth and ras_err hold regardless of the other request inputs.
REQ-017 When en=1, one operation executes per cycle, priority ret > call > jump > branch > increment; lower-priority requests in the same cycle are ignored.
REQ-018 Increment (no request): PCout <= PCout+1, modulo 2^Psize (max value wraps to 0).
REQ-019 Branch: PCout <= PCout + sign-extended offset, modulo 2^Psize; offset 0 leaves PC unchanged.
REQ-020 Jump: PCout <= target.
REQ-021 Call, not full: stack[depth] <= PCout+1 (mod 2^Psize), depth <= depth+1, PCout <= target.
REQ-022 Call, full: PCout <= target, push discarded, depth unchanged, ras_err <= 1.
REQ-023 Ret, not empty: PCout <= stack[depth-1], depth <= depth-1.
REQ-024 Ret, empty: PCout <= PCout+1, depth stays 0, ras_err <= 1.
REQ-025 New PCout is visible the cycle after the requesting edge; single-cycle latency for all operations.
REQ-026 Stack is LIFO; contents above depth are don't-care and never observable on PCout.
REQ-027 ras_err clears only on reset.
REQ-028 A single adder computes PCout + (branch ? sign-extended offset : 1); the call return address reuses this adder's +1 result.

Reset
REQ-029 nReset low asynchronously forces PCout=0, depth=0, ras_err=0; ras_empty=1, ras_full=0.
REQ-030 Stack storage is not reset; it is unreachable because depth=0.
REQ-031 A reset asserted mid-call or mid-return aborts it; the first cycle after deassertion with en=1 starts from PCout=0.

Structure
REQ-032 Shared package pc_pkg holds the default Psize and RasDepth and the enum pc_op_t {OP_HOLD, OP_INCR, OP_BRANCH, OP_JUMP, OP_CALL, OP_RET}, used by the priority decode.
REQ-033 The stack is a separate sub-module, pc_ras (push, pop, wdata, rdata, depth), instantiated once; the priority decode, adder and PC register are in pc_stack.

Verification
REQ-034 Reset, then en=1 for 70 cycles with no requests -> PCout counts 0..63, wraps to 0, reaches 5.
REQ-035 PCout=10, branch with offset=6'b111101 (-3) -> PCout=7; then offset=5 -> PCout=12; at PCout=62, offset=4 -> PCout=2.
REQ-036 PCout=3, call target=20 -> PCout=20, depth=1; at PCout=22, ret -> PCout=4, depth=0, ras_err=0.
REQ-037 Five nested calls with RasDepth=4 -> fifth call jumps, depth stays 4, ras_err=1; four rets return in LIFO order.
REQ-038 Ret with depth=0 at PCout=9 -> PCout=10, ras_err=1; call+jump+branch asserted together -> call wins.
REQ-039 en=0 with call asserted -> no change; nReset pulsed low mid-cycle after two calls -> PCout=0, depth=0 immediately.
